// File: rtl/dlfloat_pkg.sv
// Shared DLFloat definitions for the operand loader and its sanitizer.
// DLFloat 16-bit layout: [15] sign, [14:9] exponent, [8:0] mantissa.
// Optional feature macro used by the loader: DLFLOAT_OPCHECK_EN.
package dlfloat_pkg;

    localparam int unsigned DLF_W     = 16;
    localparam int unsigned DLF_EXP_W = 6;
    localparam int unsigned DLF_MAN_W = 9;

    localparam logic [DLF_W-1:0]     DLF_ZERO    = 16'h0000;
    localparam logic [DLF_W-1:0]     DLF_SPECIAL = 16'hFFFF;
    localparam logic [DLF_EXP_W-1:0] DLF_EXP_MAX = 6'h3F;

    // Loader position within a frame: next byte expected is A lo, A hi, B lo, B hi.
    typedef enum logic [1:0] {
        S_A0 = 2'd0,
        S_A1 = 2'd1,
        S_B0 = 2'd2,
        S_B1 = 2'd3
    } ld_state_e;

    function automatic logic [DLF_EXP_W-1:0] dlf_exp(input logic [DLF_W-1:0] v);
        return v[DLF_MAN_W +: DLF_EXP_W];
    endfunction

endpackage

// File: rtl/dlfloat_operand_loader_if.sv
// Stream/operand bundle between the byte source, the loader and the MAC.
//   byte_in/byte_valid/cmd_clr : source -> loader
//   op_a/op_b/op_valid/acc_clr : loader -> MAC
//   busy/frame_err/frames_done : loader status
// master: the byte source / observer side; slave: the loader.
interface dlfloat_operand_loader_if
    import dlfloat_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) ();

    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             cmd_clr;
    logic [DLF_W-1:0] op_a;
    logic [DLF_W-1:0] op_b;
    logic             op_valid;
    logic             acc_clr;
    logic             busy;
    logic             frame_err;
    logic [CNT_W-1:0] frames_done;

    modport master (
        output byte_in, byte_valid, cmd_clr,
        input  op_a, op_b, op_valid, acc_clr, busy, frame_err, frames_done
    );

    modport slave (
        input  byte_in, byte_valid, cmd_clr,
        output op_a, op_b, op_valid, acc_clr, busy, frame_err, frames_done
    );

endinterface

// File: rtl/dlfloat_opcheck.sv
// Combinational DLFloat operand sanitizer.
//   op_i : raw assembled operand
//   op_o : zero/denormal flushed to 0000, exponent-max values forced to FFFF, else op_i
module dlfloat_opcheck
    import dlfloat_pkg::*;
(
    input  logic [DLF_W-1:0] op_i,
    output logic [DLF_W-1:0] op_o
);

    logic [DLF_EXP_W-1:0] exp_field;

    assign exp_field = dlf_exp(op_i);

    always_comb begin
        op_o = op_i;
        if (exp_field == '0) begin
            op_o = DLF_ZERO;
        end else if (exp_field == DLF_EXP_MAX) begin
            op_o = DLF_SPECIAL;
        end
    end

endmodule

// File: rtl/dlfloat_operand_loader.sv
// Byte-serial DLFloat operand pair loader feeding the MAC datapath.
// Frame order: A[7:0], A[15:8], B[7:0], B[15:8]; the pair is presented for one cycle
// after the 4th byte, zeros otherwise. Includes inter-byte timeout abort, clear command
// (acc_clr pulse) and a wrapping completed-frame counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld_io      : byte stream in, operand pair / status out (slave modport)
// Macro DLFLOAT_OPCHECK_EN: when defined, operands pass through dlfloat_opcheck.
module dlfloat_operand_loader
    import dlfloat_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dlfloat_operand_loader_if.slave  ld_io
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ld_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       a_lo_q, a_lo_d;
    logic [7:0]       a_hi_q, a_hi_d;
    logic [7:0]       b_lo_q, b_lo_d;
    logic [DLF_W-1:0] op_a_q, op_a_d;
    logic [DLF_W-1:0] op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic             acc_clr_q, acc_clr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] fd_q, fd_d;

    logic [DLF_W-1:0] a_raw, b_raw;
    logic [DLF_W-1:0] a_out, b_out;

    // B hi comes straight from the bus in the completing cycle.
    assign a_raw = {a_hi_q, a_lo_q};
    assign b_raw = {ld_io.byte_in, b_lo_q};

`ifdef DLFLOAT_OPCHECK_EN
    dlfloat_opcheck u_check_a (
        .op_i (a_raw),
        .op_o (a_out)
    );

    dlfloat_opcheck u_check_b (
        .op_i (b_raw),
        .op_o (b_out)
    );
`else
    assign a_out = a_raw;
    assign b_out = b_raw;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_lo_d     = a_lo_q;
        a_hi_d     = a_hi_q;
        b_lo_d     = b_lo_q;
        op_a_d     = DLF_ZERO;
        op_b_d     = DLF_ZERO;
        op_valid_d = 1'b0;
        acc_clr_d  = 1'b0;
        err_d      = err_q;
        fd_d       = fd_q;

        // Priority: clear command, then an accepted byte, then timeout.
        if (ld_io.cmd_clr) begin
            state_d   = S_A0;
            cnt_d     = '0;
            err_d     = 1'b0;
            acc_clr_d = 1'b1;
        end else if (ld_io.byte_valid) begin
            cnt_d = '0;
            unique case (state_q)
                S_A0: begin
                    a_lo_d  = ld_io.byte_in;
                    state_d = S_A1;
                end
                S_A1: begin
                    a_hi_d  = ld_io.byte_in;
                    state_d = S_B0;
                end
                S_B0: begin
                    b_lo_d  = ld_io.byte_in;
                    state_d = S_B1;
                end
                S_B1: begin
                    state_d    = S_A0;
                    op_valid_d = 1'b1;
                    op_a_d     = a_out;
                    op_b_d     = b_out;
                    fd_d       = fd_q + CNT_W'(1);
                end
                default: state_d = S_A0;
            endcase
        end else if (state_q == S_A0) begin
            cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
            state_d = S_A0;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A0;
            cnt_q      <= '0;
            a_lo_q     <= '0;
            a_hi_q     <= '0;
            b_lo_q     <= '0;
            op_a_q     <= DLF_ZERO;
            op_b_q     <= DLF_ZERO;
            op_valid_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            err_q      <= 1'b0;
            fd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_lo_q     <= a_lo_d;
            a_hi_q     <= a_hi_d;
            b_lo_q     <= b_lo_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            acc_clr_q  <= acc_clr_d;
            err_q      <= err_d;
            fd_q       <= fd_d;
        end
    end

    assign ld_io.op_a        = op_a_q;
    assign ld_io.op_b        = op_b_q;
    assign ld_io.op_valid    = op_valid_q;
    assign ld_io.acc_clr     = acc_clr_q;
    assign ld_io.busy        = (state_q != S_A0);
    assign ld_io.frame_err   = err_q;
    assign ld_io.frames_done = fd_q;

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Directed bench for dlfloat_operand_loader with an operand-pair scoreboard.
module tb_dlfloat_operand_loader;

    localparam int unsigned TO = 255;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  fd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    dlfloat_operand_loader_if #(.CNT_W(8)) ifc ();

    dlfloat_operand_loader #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_io (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every op_valid pops one expected pair; other cycles must be zero.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (ifc.op_valid) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_op_valid: observed %h/%h expected no pulse",
                           ifc.op_a, ifc.op_b);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pair", {24'h0, ifc.op_a, ifc.op_b, ifc.frames_done},
                        {24'h0, e.a, e.b, e.fd});
                end
            end else begin
                chk("zero_insert", {32'h0, ifc.op_a, ifc.op_b}, 64'h0);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] b, input logic c);
        ifc.byte_valid = v;
        ifc.byte_in    = b;
        ifc.cmd_clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] fd);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.fd = fd;
        exp_q.push_back(e);
        step(1'b1, a[7:0], 1'b0);
        step(1'b1, a[15:8], 1'b0);
        step(1'b1, b[7:0], 1'b0);
        step(1'b1, b[15:8], 1'b0);
    endtask

    function automatic logic [15:0] san(input logic [15:0] v);
`ifdef DLFLOAT_OPCHECK_EN
        if (v[14:9] == 6'h00) return 16'h0000;
        if (v[14:9] == 6'h3F) return 16'hFFFF;
`endif
        return v;
    endfunction

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        ifc.cmd_clr    = 1'b0;

        #12;
        chk("reset_outputs", {20'h0, ifc.op_valid, ifc.acc_clr, ifc.busy, ifc.frame_err,
                              ifc.frames_done, ifc.op_a, ifc.op_b}, 64'h0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single frame, one-cycle pulse then zero insertion
        frame(16'h3E00, 16'h4000, 8'd1);
        chk("t1_valid", {63'h0, ifc.op_valid}, 64'h1);
        chk("t1_busy_after", {63'h0, ifc.busy}, 64'h0);
        idle(1);
        chk("t1_pulse_end", {63'h0, ifc.op_valid}, 64'h0);
        chk("t1_fd", {56'h0, ifc.frames_done}, 64'd1);

        // 2: back-to-back frames with byte_valid held high
        frame(16'h1234, 16'h5678, 8'd2);
        chk("t2_first", {63'h0, ifc.op_valid}, 64'h1);
        step(1'b1, 8'hBC, 1'b0);
        chk("t2_gap", {63'h0, ifc.op_valid}, 64'h0);
        exp_q.push_back('{a: 16'h9ABC, b: 16'hDEF0, fd: 8'd3});
        step(1'b1, 8'h9A, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'hDE, 1'b0);
        chk("t2_second", {63'h0, ifc.op_valid}, 64'h1);
        idle(2);
        chk("t2_fd", {56'h0, ifc.frames_done}, 64'd3);

        // 3: timeout after two bytes, exactly TO idle cycles to abort
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        idle(TO - 1);
        chk("t3_busy_before_to", {62'h0, ifc.busy, ifc.frame_err}, 64'h2);
        idle(1);
        chk("t3_aborted", {62'h0, ifc.busy, ifc.frame_err}, 64'h1);
        frame(16'h4A55, 16'h3C66, 8'd4);
        idle(1);
        chk("t3_err_sticky", {55'h0, ifc.frame_err, ifc.frames_done}, {55'h0, 1'b1, 8'd4});

        // 4: clear together with the 3rd byte drops it and restarts
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b1);
        chk("t4_clr", {60'h0, ifc.acc_clr, ifc.busy, ifc.frame_err, ifc.op_valid}, 64'h8);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_clr_held", {63'h0, ifc.acc_clr}, 64'h1);
        idle(1);
        chk("t4_clr_end", {63'h0, ifc.acc_clr}, 64'h0);
        frame(16'h2345, 16'h6789, 8'd5);
        idle(1);
        chk("t4_fd_kept", {56'h0, ifc.frames_done}, 64'd5);

        // 5: sanitizer (or bit-exact passthrough without the macro)
        frame(san(16'h0005), san(16'h7E01), 8'd6);
        idle(1);

        // 6: async reset mid-frame
        step(1'b1, 8'h77, 1'b0);
        idle(TO);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        chk("t6_pre_reset", {60'h0, ifc.busy, ifc.frame_err, 2'b0}, 64'hC);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {20'h0, ifc.op_valid, ifc.acc_clr, ifc.busy, ifc.frame_err,
                               ifc.frames_done, ifc.op_a, ifc.op_b}, 64'h0);
        ifc.byte_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // frames_done wraps 255 -> 0
        for (int i = 0; i < 255; i++) begin
            frame(16'h3E00 | 16'(i), 16'h4000 | 16'(i), 8'(i + 1));
        end
        idle(1);
        chk("t6_fd_255", {56'h0, ifc.frames_done}, 64'd255);
        frame(16'h3E55, 16'h4055, 8'd0);
        idle(1);
        chk("t6_fd_wrap", {56'h0, ifc.frames_done}, 64'd0);
        idle(2);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
